// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 multi-channel memory port.
// Optional wait-state timeout is enabled with LC3_MEMPORT_TIMEOUT_EN.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // A single channel still needs a 1-bit index
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lc3_mem_port_arb.sv
// Combinational round-robin arbiter: search starts one past the
// previous winner and wraps modulo NCH.
module lc3_rr_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0]          req,
  input  logic [idx_w(NCH)-1:0]   last,
  output logic [NCH-1:0]          onehot,
  output logic [idx_w(NCH)-1:0]   idx
);

  localparam int IW = idx_w(NCH);

  logic          w_hit;
  logic [IW-1:0] w_c;

  always_comb begin
    onehot = '0;
    idx    = '0;
    w_hit  = 1'b0;
    w_c    = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_c = IW'((int'(last) + k) % NCH);
      if (!w_hit && req[w_c]) begin
        w_hit       = 1'b1;
        idx         = w_c;
        onehot[w_c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_port.sv
// Round-robin multi-channel front end for the LC3 memory handshake.
// Define LC3_MEMPORT_TIMEOUT_EN to abort accesses after TIMEOUT BUSY cycles.
module lc3_mem_port
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NCH     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        req_we,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  output logic [NCH-1:0]        gnt,
  output logic [NCH-1:0]        done,
  output logic [NCH-1:0]        err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     din,
  input  logic [DATA_W-1:0]     dout,
  output logic                  rd,
  input  logic                  complete
);

  localparam int IW = idx_w(NCH);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("lc3_mem_port: NCH must be 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_to
    $error("lc3_mem_port: TIMEOUT must be 1..255");
  end

  state_t            r_state, w_state_nx;
  logic [IW-1:0]     r_last, w_last_nx;
  logic [IW-1:0]     r_win, w_win_nx;
  logic [NCH-1:0]    r_gnt, w_gnt_nx;
  logic [NCH-1:0]    r_done, w_done_nx;
  logic [DATA_W-1:0] r_rdata, w_rdata_nx;
  logic              r_mem_en, w_mem_en_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_din, w_din_nx;
  logic              r_rd, w_rd_nx;

  logic [NCH-1:0]    w_onehot;
  logic [IW-1:0]     w_idx;

`ifdef LC3_MEMPORT_TIMEOUT_EN
  logic [NCH-1:0]    r_err, w_err_nx;
  logic [7:0]        r_cnt, w_cnt_nx;
`endif

  lc3_rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req    (req),
    .last   (r_last),
    .onehot (w_onehot),
    .idx    (w_idx)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_last_nx   = r_last;
    w_win_nx    = r_win;
    w_gnt_nx    = '0;
    w_done_nx   = '0;
    w_rdata_nx  = r_rdata;
    w_mem_en_nx = 1'b0;
    w_addr_nx   = r_addr;
    w_din_nx    = r_din;
    w_rd_nx     = r_rd;
`ifdef LC3_MEMPORT_TIMEOUT_EN
    w_err_nx    = '0;
    w_cnt_nx    = r_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nx  = S_BUSY;
          w_last_nx   = w_idx;
          w_win_nx    = w_idx;
          w_gnt_nx    = w_onehot;
          w_mem_en_nx = 1'b1;
          w_addr_nx   = req_addr[w_idx*ADDR_W +: ADDR_W];
          w_din_nx    = req_wdata[w_idx*DATA_W +: DATA_W];
          w_rd_nx     = req_we[w_idx] ? MEM_WR : MEM_RD;
`ifdef LC3_MEMPORT_TIMEOUT_EN
          w_cnt_nx    = '0;
`endif
        end
      end
      S_BUSY: begin
        w_mem_en_nx = 1'b1;
        if (complete) begin
          w_state_nx       = S_DONE;
          w_mem_en_nx      = 1'b0;
          w_done_nx[r_win] = 1'b1;
          if (r_rd == MEM_RD) w_rdata_nx = dout;
        end
`ifdef LC3_MEMPORT_TIMEOUT_EN
        // r_cnt holds the number of BUSY cycles already finished
        else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_state_nx       = S_DONE;
          w_mem_en_nx      = 1'b0;
          w_done_nx[r_win] = 1'b1;
          w_err_nx[r_win]  = 1'b1;
          w_rdata_nx       = '0;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
`endif
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= IW'(NCH - 1);
      r_win    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_mem_en <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_rd     <= MEM_RD;
    end else begin
      r_state  <= w_state_nx;
      r_last   <= w_last_nx;
      r_win    <= w_win_nx;
      r_gnt    <= w_gnt_nx;
      r_done   <= w_done_nx;
      r_rdata  <= w_rdata_nx;
      r_mem_en <= w_mem_en_nx;
      r_addr   <= w_addr_nx;
      r_din    <= w_din_nx;
      r_rd     <= w_rd_nx;
    end
  end

`ifdef LC3_MEMPORT_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= '0;
      r_cnt <= '0;
    end else begin
      r_err <= w_err_nx;
      r_cnt <= w_cnt_nx;
    end
  end

  assign err = r_err;
`else
  assign err = '0;
`endif

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign rdata  = r_rdata;
  assign mem_en = r_mem_en;
  assign addr   = r_addr;
  assign din    = r_din;
  assign rd     = r_rd;

endmodule
